vram_arbiter: RTL

- Shares one single-port synchronous RAM (2K x 8 class, 1-cycle read latency, write-enable selects write vs read) between the Z80 CPU bus and the tile/sprite video fetcher.
- Video fetch has priority. A deferral counter guarantees CPU forward progress by stalling the fetcher.
- Sits between the CPU address decoder and a VRAM/work-RAM instance in the video subsystem.

---
 rtl/vram_arb_pkg.sv | 20 ++
 rtl/vram_arb_tagpipe.sv | 48 ++++
 rtl/vram_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: access tags carried down the read pipeline
// and the per-cycle grant decision.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VID    = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } tag_t;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } grant_t;

    localparam int DEFAULT_MAX_DEFER = 8;

endpackage

// File: rtl/vram_arb_tagpipe.sv
// Two-stage tag pipeline: tracks each granted access through the RAM's read
// latency, captures read data and emits the completion pulses.
module vram_arb_tagpipe
    import vram_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  grant_t        grant,
    input  logic          cpu_we,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid
);

    tag_t tag_in, stage1, stage2;

    always_comb begin
        tag_in = TAG_NONE;
        case (grant)
            GNT_VID: tag_in = TAG_VID;
            GNT_CPU: tag_in = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            default: tag_in = TAG_NONE;
        endcase
    end

    // ram_dout is valid the cycle after the address, i.e. while the tag sits in stage1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1   <= TAG_NONE;
            stage2   <= TAG_NONE;
            cpu_dout <= '0;
            vid_dout <= '0;
        end else begin
            stage1 <= tag_in;
            stage2 <= stage1;
            if (stage1 == TAG_VID)    vid_dout <= ram_dout;
            if (stage1 == TAG_CPU_RD) cpu_dout <= ram_dout;
        end
    end

    assign vid_valid = (stage2 == TAG_VID);
    assign cpu_ack   = (stage2 == TAG_CPU_RD) || (stage2 == TAG_CPU_WR);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has priority, a deferral counter forces
// a starved CPU access through by stalling the fetcher for one cycle.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW        = 11,
    parameter int DW        = 8,
    parameter int MAX_DEFER = DEFAULT_MAX_DEFER
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic          vid_stall,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    output logic [AW-1:0] ram_adr,
    output logic          ram_wr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [7:0] DEFER_LIM = 8'(MAX_DEFER);

    logic       cpu_busy;
    logic [7:0] defer_cnt;
    logic       cpu_pend, force_cpu;
    grant_t     grant;

    assign cpu_pend  = cpu_req & ~cpu_busy;
    assign force_cpu = cpu_pend & (defer_cnt == DEFER_LIM);

    always_comb begin
        grant     = GNT_IDLE;
        vid_stall = 1'b0;
        if (force_cpu) begin
            grant     = GNT_CPU;
            vid_stall = vid_req;
        end else if (vid_req) begin
            grant = GNT_VID;
        end else if (cpu_pend) begin
            grant = GNT_CPU;
        end
    end

    always_comb begin
        ram_adr = cpu_adr;
        ram_wr  = 1'b0;
        ram_din = cpu_din;
        case (grant)
            GNT_VID: ram_adr = vid_adr;
            GNT_CPU: ram_wr  = cpu_we;
            default: ram_wr  = 1'b0;
        endcase
    end

    // Held request waits from first assertion until its ack, except in the grant cycle
    assign cpu_wait = cpu_req & ~cpu_ack & (grant != GNT_CPU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_busy  <= 1'b0;
            defer_cnt <= '0;
        end else begin
            if (grant == GNT_CPU) cpu_busy <= 1'b1;
            else if (cpu_ack)     cpu_busy <= 1'b0;

            if (grant == GNT_CPU || !cpu_pend) defer_cnt <= '0;
            else if (defer_cnt != DEFER_LIM)   defer_cnt <= defer_cnt + 8'd1;
        end
    end

    vram_arb_tagpipe #(.DW(DW)) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant),
        .cpu_we    (cpu_we),
        .ram_dout  (ram_dout),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .vid_dout  (vid_dout),
        .vid_valid (vid_valid)
    );

endmodule
